// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between the E-stage sequencer and the multiply/divide unit.
interface muldiv_unit_if;
   logic        Start;
   logic        Req;
   logic [3:0]  MDOp;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (
      output Start, Req, MDOp, SrcA, SrcB,
      input  Busy, HI, LO
   );

   modport slave (
      input  Start, Req, MDOp, SrcA, SrcB,
      output Busy, HI, LO
   );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO, with a busy countdown modelling op latency.
// Define MDU_MADD_EN to enable the madd/maddu/msub/msubu accumulate ops (MDOp 7-10).
module muldiv_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input logic          clk,
   input logic          reset,
   muldiv_unit_if.slave md
);

   localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CntW      = $clog2(MaxCycles + 1);

   localparam logic [3:0] OpMult  = 4'd1;
   localparam logic [3:0] OpMultu = 4'd2;
   localparam logic [3:0] OpDiv   = 4'd3;
   localparam logic [3:0] OpDivu  = 4'd4;
   localparam logic [3:0] OpMthi  = 4'd5;
   localparam logic [3:0] OpMtlo  = 4'd6;
`ifdef MDU_MADD_EN
   localparam logic [3:0] OpMadd  = 4'd7;
   localparam logic [3:0] OpMaddu = 4'd8;
   localparam logic [3:0] OpMsub  = 4'd9;
   localparam logic [3:0] OpMsubu = 4'd10;
`endif

   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic [31:0]       hi_q, hi_d;
   logic [31:0]       lo_q, lo_d;
   logic [31:0]       ph_q, ph_d;
   logic [31:0]       pl_q, pl_d;
   logic              wr_q, wr_d;

   // Op decode
   logic is_mul_s, is_mul_u, is_div_s, is_div_u, is_mthi, is_mtlo;
   logic is_acc, acc_signed, acc_sub;
   logic op_valid, op_long, issue;

   always_comb begin
      is_mul_s   = (md.MDOp == OpMult);
      is_mul_u   = (md.MDOp == OpMultu);
      is_div_s   = (md.MDOp == OpDiv);
      is_div_u   = (md.MDOp == OpDivu);
      is_mthi    = (md.MDOp == OpMthi);
      is_mtlo    = (md.MDOp == OpMtlo);
      is_acc     = 1'b0;
      acc_signed = 1'b0;
      acc_sub    = 1'b0;
`ifdef MDU_MADD_EN
      is_acc     = (md.MDOp == OpMadd) || (md.MDOp == OpMaddu) ||
                   (md.MDOp == OpMsub) || (md.MDOp == OpMsubu);
      acc_signed = (md.MDOp == OpMadd) || (md.MDOp == OpMsub);
      acc_sub    = (md.MDOp == OpMsub) || (md.MDOp == OpMsubu);
`endif
      op_long  = is_mul_s | is_mul_u | is_div_s | is_div_u | is_acc;
      op_valid = op_long | is_mthi | is_mtlo;
      issue    = md.Start & ~md.Req & ~busy_q & op_valid;
   end

   // Products, sign-extended to 64 bits so the low 64 bits of the 64x64 multiply are exact.
   logic [63:0] prod_s, prod_u;

   always_comb begin
      prod_s = {{32{md.SrcA[31]}}, md.SrcA} * {{32{md.SrcB[31]}}, md.SrcB};
      prod_u = {32'd0, md.SrcA} * {32'd0, md.SrcB};
   end

   // Division runs on magnitudes so the 0x80000000 / -1 case needs no special handling.
   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag, b_safe;
   logic [31:0] qs_mag, rs_mag, q_s, r_s;
   logic [31:0] q_u, r_u;
   logic        div_zero;

   always_comb begin
      a_neg    = md.SrcA[31];
      b_neg    = md.SrcB[31];
      a_mag    = a_neg ? (32'd0 - md.SrcA) : md.SrcA;
      b_mag    = b_neg ? (32'd0 - md.SrcB) : md.SrcB;
      div_zero = (md.SrcB == 32'd0);
      b_safe   = div_zero ? 32'd1 : b_mag;
      qs_mag   = a_mag / b_safe;
      rs_mag   = a_mag % b_safe;
      q_s      = (a_neg ^ b_neg) ? (32'd0 - qs_mag) : qs_mag;
      r_s      = a_neg ? (32'd0 - rs_mag) : rs_mag;
      q_u      = md.SrcA / (div_zero ? 32'd1 : md.SrcB);
      r_u      = md.SrcA % (div_zero ? 32'd1 : md.SrcB);
   end

   // 64-bit pending result selected by op
   logic [63:0] res;
   logic [63:0] acc_prod;

   always_comb begin
      acc_prod = acc_signed ? prod_s : prod_u;
      res      = 64'd0;
      if (is_mul_s) begin
         res = prod_s;
      end else if (is_mul_u) begin
         res = prod_u;
      end else if (is_div_s) begin
         res = {r_s, q_s};
      end else if (is_div_u) begin
         res = {r_u, q_u};
      end else if (is_acc) begin
         res = acc_sub ? ({hi_q, lo_q} - acc_prod) : ({hi_q, lo_q} + acc_prod);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      ph_d    = ph_q;
      pl_d    = pl_q;
      wr_d    = wr_q;
      case (state_q)
         StIdle: begin
            if (issue) begin
               if (is_mthi) begin
                  hi_d = md.SrcA;
               end else if (is_mtlo) begin
                  lo_d = md.SrcA;
               end else if (op_long) begin
                  ph_d    = res[63:32];
                  pl_d    = res[31:0];
                  // A zero divisor still takes the full latency but never commits.
                  wr_d    = ~((is_div_s | is_div_u) & div_zero);
                  cnt_d   = (is_div_s | is_div_u) ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
                  busy_d  = 1'b1;
                  state_d = StBusy;
               end
            end
         end
         StBusy: begin
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
               busy_d  = 1'b0;
               state_d = StIdle;
               if (wr_q) begin
                  hi_d = ph_q;
                  lo_d = pl_q;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         ph_q    <= 32'd0;
         pl_q    <= 32'd0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         ph_q    <= ph_d;
         pl_q    <= pl_d;
         wr_q    <= wr_d;
      end
   end

   assign md.Busy = busy_q;
   assign md.HI   = hi_q;
   assign md.LO   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized bench for muldiv_unit against a longint-arithmetic reference model.
module tb_muldiv_unit;

   localparam int MulN = 5;
   localparam int DivN = 10;

   logic clk = 1'b0;
   logic reset;

   muldiv_unit_if md ();

   muldiv_unit #(
      .MULT_CYCLES(MulN),
      .DIV_CYCLES (DivN)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .md   (md)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   logic [31:0] hi_m, lo_m;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference: architectural effect of one op on {HI,LO} plus its Busy length.
   function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output int cyc, output logic [31:0] nh, output logic [31:0] nl);
      longint sa, sb, q, r, ps;
      longint unsigned pu, acc;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      pu  = longint'({32'd0, a}) * longint'({32'd0, b});
      ps  = sa * sb;
      acc = {hi_m, lo_m};
      cyc = 0;
      nh  = hi_m;
      nl  = lo_m;
      case (op)
         4'd1: begin cyc = MulN; nh = ps[63:32]; nl = ps[31:0]; end
         4'd2: begin cyc = MulN; nh = pu[63:32]; nl = pu[31:0]; end
         4'd3: begin
            cyc = DivN;
            if (b != 0) begin
               q  = sa / sb;
               r  = sa % sb;
               nl = q[31:0];
               nh = r[31:0];
            end
         end
         4'd4: begin
            cyc = DivN;
            if (b != 0) begin
               nl = a / b;
               nh = a % b;
            end
         end
         4'd5: nh = a;
         4'd6: nl = a;
`ifdef MDU_MADD_EN
         4'd7: begin cyc = MulN; acc = acc + longint'(ps); nh = acc[63:32]; nl = acc[31:0]; end
         4'd8: begin cyc = MulN; acc = acc + pu; nh = acc[63:32]; nl = acc[31:0]; end
         4'd9: begin cyc = MulN; acc = acc - longint'(ps); nh = acc[63:32]; nl = acc[31:0]; end
         4'd10: begin cyc = MulN; acc = acc - pu; nh = acc[63:32]; nl = acc[31:0]; end
`endif
         default: ;
      endcase
   endfunction

   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
      int cyc, n;
      logic [31:0] nh, nl;
      model(op, a, b, cyc, nh, nl);
      @(negedge clk);
      md.Start = 1'b1;
      md.MDOp  = op;
      md.SrcA  = a;
      md.SrcB  = b;
      @(negedge clk);
      md.Start = 1'b0;
      n = 0;
      while (md.Busy === 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
      end
      check({tag, "/busy_cycles"}, 32'(n), 32'(cyc));
      check({tag, "/hi"}, md.HI, nh);
      check({tag, "/lo"}, md.LO, nl);
      hi_m = nh;
      lo_m = nl;
   endtask

   initial begin
      int n, cyc;
      logic [31:0] nh, nl, a, b;
      logic [3:0] op;

      reset    = 1'b1;
      md.Start = 1'b0;
      md.Req   = 1'b0;
      md.MDOp  = 4'd0;
      md.SrcA  = 32'd0;
      md.SrcB  = 32'd0;
      hi_m     = 32'd0;
      lo_m     = 32'd0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("reset/busy", {31'd0, md.Busy}, 32'd0);
      check("reset/hi", md.HI, 32'd0);
      check("reset/lo", md.LO, 32'd0);

      run_op("mult", 4'd1, 32'hFFFFFFFE, 32'd3);
      check("mult/hi_const", md.HI, 32'hFFFFFFFF);
      check("mult/lo_const", md.LO, 32'hFFFFFFFA);
      run_op("multu", 4'd2, 32'hFFFFFFFE, 32'd3);
      check("multu/hi_const", md.HI, 32'h00000002);
      run_op("div", 4'd3, 32'hFFFFFFF9, 32'd2);
      check("div/lo_const", md.LO, 32'hFFFFFFFD);
      check("div/hi_const", md.HI, 32'hFFFFFFFF);
      run_op("mthi_pre", 4'd5, 32'h11, 32'd0);
      run_op("mtlo_pre", 4'd6, 32'h22, 32'd0);
      run_op("divu_zero", 4'd4, 32'd7, 32'd0);
      check("divu_zero/hi_const", md.HI, 32'h11);
      run_op("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF);
      check("div_ovf/lo_const", md.LO, 32'h80000000);
      check("div_ovf/hi_const", md.HI, 32'h00000000);
      run_op("undef_op", 4'd12, 32'h5, 32'h6);

      // mthi then mtlo on back-to-back cycles
      @(negedge clk);
      md.Start = 1'b1;
      md.MDOp  = 4'd5;
      md.SrcA  = 32'hDEADBEEF;
      @(negedge clk);
      check("mthi_b2b/hi", md.HI, 32'hDEADBEEF);
      check("mthi_b2b/busy", {31'd0, md.Busy}, 32'd0);
      md.MDOp = 4'd6;
      md.SrcA = 32'h12345678;
      @(negedge clk);
      md.Start = 1'b0;
      check("mtlo_b2b/lo", md.LO, 32'h12345678);
      check("mtlo_b2b/hi", md.HI, 32'hDEADBEEF);
      check("mtlo_b2b/busy", {31'd0, md.Busy}, 32'd0);
      hi_m = 32'hDEADBEEF;
      lo_m = 32'h12345678;

      // Start suppressed by Req
      md.Start = 1'b1;
      md.Req   = 1'b1;
      md.MDOp  = 4'd1;
      md.SrcA  = 32'd9;
      md.SrcB  = 32'd9;
      @(negedge clk);
      md.Start = 1'b0;
      md.Req   = 1'b0;
      check("req_block/busy", {31'd0, md.Busy}, 32'd0);
      @(negedge clk);
      check("req_block/busy2", {31'd0, md.Busy}, 32'd0);
      check("req_block/hi", md.HI, hi_m);
      check("req_block/lo", md.LO, lo_m);

      // Req and Start during an in-flight div must not disturb it
      model(4'd3, 32'd100, 32'd7, cyc, nh, nl);
      md.Start = 1'b1;
      md.MDOp  = 4'd3;
      md.SrcA  = 32'd100;
      md.SrcB  = 32'd7;
      @(negedge clk);
      md.Start = 1'b0;
      n = 0;
      while (md.Busy === 1'b1 && n < 200) begin
         n++;
         md.Req = (n == 3);
         if (n == 4) begin
            md.Start = 1'b1;
            md.MDOp  = 4'd1;
            md.SrcA  = 32'd3;
            md.SrcB  = 32'd5;
         end else begin
            md.Start = 1'b0;
         end
         @(negedge clk);
      end
      md.Start = 1'b0;
      md.Req   = 1'b0;
      check("overlap/busy_cycles", 32'(n), 32'(cyc));
      check("overlap/hi", md.HI, nh);
      check("overlap/lo", md.LO, nl);
      @(negedge clk);
      check("overlap/no_mult", {31'd0, md.Busy}, 32'd0);
      hi_m = nh;
      lo_m = nl;

      // Asynchronous reset in the middle of a mult
      md.Start = 1'b1;
      md.MDOp  = 4'd1;
      md.SrcA  = 32'h1234;
      md.SrcB  = 32'h5678;
      @(negedge clk);
      md.Start = 1'b0;
      @(negedge clk);
      #1 reset = 1'b1;
      #1;
      check("async_rst/busy", {31'd0, md.Busy}, 32'd0);
      check("async_rst/hi", md.HI, 32'd0);
      check("async_rst/lo", md.LO, 32'd0);
      #1 reset = 1'b0;
      repeat (8) @(negedge clk);
      check("async_rst/busy_after", {31'd0, md.Busy}, 32'd0);
      check("async_rst/hi_after", md.HI, 32'd0);
      check("async_rst/lo_after", md.LO, 32'd0);
      hi_m = 32'd0;
      lo_m = 32'd0;

      // Accumulate ops (or decode as none when disabled)
      run_op("madd_pre_hi", 4'd5, 32'd0, 32'd0);
      run_op("madd_pre_lo", 4'd6, 32'hFFFFFFFF, 32'd0);
      run_op("madd", 4'd7, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
      check("madd/hi_const", md.HI, 32'd1);
      check("madd/lo_const", md.LO, 32'd0);
`else
      check("madd_off/hi_const", md.HI, 32'd0);
      check("madd_off/lo_const", md.LO, 32'hFFFFFFFF);
`endif
      run_op("msub", 4'd9, 32'hFFFFFFFF, 32'd3);

      for (int i = 0; i < 24; i++) begin
         op = 4'($urandom_range(1, 11));
         a  = $urandom;
         b  = $urandom;
         if ((op == 4'd3 || op == 4'd4) && $urandom_range(0, 3) == 0) b = 32'd0;
         if ($urandom_range(0, 3) == 0) b = b & 32'h0000000F;
         run_op($sformatf("rand%0d_op%0d", i, op), op, a, b);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
